// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-source UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int ARB_NREQ            = 2;
    localparam int ARB_TIMEOUT_DEFAULT = 255;

    // Keeps the idle counter at least one bit wide when the timeout is disabled.
    function automatic int arb_cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-deep 8-bit valid/ready output register feeding the UART transmitter.
module axis_out_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       m_tready,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    output logic       free
);

    // Free when empty or draining this cycle, so load and drain can overlap.
    assign free = !m_tvalid || m_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tdata  <= 8'h00;
            m_tvalid <= 1'b0;
        end else if (load) begin
            m_tdata  <= load_data;
            m_tvalid <= 1'b1;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter between two byte sources and one UART
// transmitter input; a grant is dropped if its owner goes quiet mid-packet.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s0_tdata,
    input  logic       s0_tvalid,
    input  logic       s0_tlast,
    output logic       s0_tready,
    input  logic [7:0] s1_tdata,
    input  logic       s1_tvalid,
    input  logic       s1_tlast,
    output logic       s1_tready,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic [1:0] grant,
    output logic       timeout_pulse
);

    localparam int              CW       = arb_cnt_width(TIMEOUT);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0]   CNT_FIRE = CW'(TIMEOUT - 1);

    arb_state_t            state, state_next;
    logic                  last_owner;
    logic [CW-1:0]         cnt;
    logic [ARB_NREQ-1:0]   req_valid, req_last;
    logic                  owned, owner;
    logic                  sel_valid, sel_last;
    logic [7:0]            sel_data;
    logic                  out_free, accept, pkt_end, fire;

    assign req_valid = {s1_tvalid, s0_tvalid};
    assign req_last  = {s1_tlast, s0_tlast};
    assign owned     = (state != IDLE);
    assign owner     = (state == OWN1);
    assign sel_valid = req_valid[owner];
    assign sel_last  = req_last[owner];
    assign sel_data  = owner ? s1_tdata : s0_tdata;
    assign accept    = owned && sel_valid && out_free;
    assign pkt_end   = accept && sel_last;
    // Fires on the TIMEOUT-th empty owner cycle, so IDLE follows immediately.
    assign fire      = owned && (TIMEOUT != 0) && !sel_valid && (cnt == CNT_FIRE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (s0_tvalid && s1_tvalid) state_next = last_owner ? OWN0 : OWN1;
                else if (s0_tvalid)         state_next = OWN0;
                else if (s1_tvalid)         state_next = OWN1;
            end
            OWN0, OWN1: begin
                if (pkt_end || fire) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s0_tready = (state == OWN0) && out_free;
        s1_tready = (state == OWN1) && out_free;
        grant     = {state == OWN1, state == OWN0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner    <= 1'b1;
            cnt           <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= fire;
            if (pkt_end || fire) last_owner <= owner;
            // Backpressure with valid held high neither counts nor clears.
            if (!owned || accept)                   cnt <= '0;
            else if (!sel_valid && cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
    end

    axis_out_reg u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_data (sel_data),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .free      (out_free)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a per-cycle behavioural model.
module tb_uart_tx_arbiter;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s0_tdata, s1_tdata, m_tdata;
    logic       s0_tvalid, s0_tlast, s0_tready;
    logic       s1_tvalid, s1_tlast, s1_tready;
    logic       m_tvalid, m_tready, timeout_pulse;
    logic [1:0] grant;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .grant(grant), .timeout_pulse(timeout_pulse)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Source queues hold {tlast, byte}; drained/exp_q are output-order scoreboards.
    logic [8:0] q0[$], q1[$];
    logic [7:0] drained[$], exp_q[$];

    // Model: owner -1 = nobody; idle counts empty owner cycles since the last beat.
    int         mo_own, mo_last, mo_idle;
    bit         mo_v, mo_pulse;
    logic [7:0] mo_d;
    int         pulses;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mo_own = -1; mo_last = 1; mo_idle = 0;
        mo_v = 0; mo_pulse = 0; mo_d = 8'h00;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_rdy0"}, 32'(s0_tready), 0);
        chk({tag, "_rdy1"}, 32'(s1_tready), 0);
        chk({tag, "_mvalid"}, 32'(m_tvalid), 0);
        chk({tag, "_mdata"}, 32'(m_tdata), 0);
        chk({tag, "_pulse"}, 32'(timeout_pulse), 0);
    endtask

    task automatic push_pkt(input int src, input int len);
        for (int i = 0; i < len; i++) begin
            logic [8:0] e;
            e = {(i == len - 1), 8'($urandom)};
            if (src == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic push_byte(input int src, input logic [7:0] d, input bit last);
        if (src == 0) q0.push_back({last, d}); else q1.push_back({last, d});
    endtask

    // One clock: drive inputs, check all outputs mid-cycle, then advance the model.
    task automatic step(input int pv, input int pr);
        bit v0, v1, free, acc, cur_v, cur_l;
        logic [8:0] h0, h1, hc;
        int eg;
        h0 = (q0.size() > 0) ? q0[0] : 9'h0;
        h1 = (q1.size() > 0) ? q1[0] : 9'h0;
        v0 = (q0.size() > 0) && (int'($urandom_range(99)) < pv);
        v1 = (q1.size() > 0) && (int'($urandom_range(99)) < pv);
        s0_tvalid = v0; s0_tdata = v0 ? h0[7:0] : 8'h00; s0_tlast = v0 & h0[8];
        s1_tvalid = v1; s1_tdata = v1 ? h1[7:0] : 8'h00; s1_tlast = v1 & h1[8];
        m_tready  = (int'($urandom_range(99)) < pr);
        @(negedge clk);
        free  = !mo_v || m_tready;
        cur_v = (mo_own == 0) ? v0 : (mo_own == 1) ? v1 : 1'b0;
        hc    = (mo_own == 1) ? h1 : h0;
        cur_l = hc[8];
        acc   = (mo_own >= 0) && cur_v && free;
        eg    = (mo_own == 0) ? 1 : (mo_own == 1) ? 2 : 0;
        chk("grant", 32'(grant), 32'(eg));
        chk("s0_tready", 32'(s0_tready), 32'((mo_own == 0) && free));
        chk("s1_tready", 32'(s1_tready), 32'((mo_own == 1) && free));
        chk("m_tvalid", 32'(m_tvalid), 32'(mo_v));
        chk("m_tdata", 32'(m_tdata), 32'(mo_d));
        chk("timeout_pulse", 32'(timeout_pulse), 32'(mo_pulse));
        if (timeout_pulse) pulses++;
        if (m_tvalid && m_tready) drained.push_back(m_tdata);
        @(posedge clk);
        mo_pulse = 0;
        if (mo_own < 0) begin
            mo_idle = 0;
            if (v0 && v1)  mo_own = (mo_last == 0) ? 1 : 0;
            else if (v0)   mo_own = 0;
            else if (v1)   mo_own = 1;
        end else if (acc) begin
            mo_idle = 0;
            if (cur_l) begin mo_last = mo_own; mo_own = -1; end
        end else if (!cur_v) begin
            mo_idle++;
            if (T != 0 && mo_idle == T) begin
                mo_last = mo_own; mo_own = -1; mo_pulse = 1;
            end
        end
        if (acc) begin
            mo_v = 1; mo_d = hc[7:0];
            if (eg == 1) void'(q0.pop_front()); else void'(q1.pop_front());
        end else if (m_tready) begin
            mo_v = 0;
        end
        #1;
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, "_len"}, 32'(drained.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < drained.size(); i++)
            chk(tag, 32'(drained[i]), 32'(exp_q[i]));
        drained.delete();
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; m_tready = 1'b0;
        s0_tvalid = 0; s0_tdata = 0; s0_tlast = 0;
        s1_tvalid = 0; s1_tdata = 0; s1_tlast = 0;
        pulses = 0;
        model_reset();
        @(negedge clk);
        chk_reset_outs("reset");
        @(posedge clk); #1; rst = 1'b0;

        // Tie from reset goes to s0, whole packets, then the next tie to s0 again.
        push_byte(0, 8'hAA, 0); push_byte(0, 8'hAB, 1);
        push_byte(1, 8'hBA, 0); push_byte(1, 8'hBB, 1);
        for (int i = 0; i < 10; i++) step(100, 100);
        exp_q = '{8'hAA, 8'hAB, 8'hBA, 8'hBB};
        chk_seq("tie");
        push_byte(0, 8'hC0, 0); push_byte(0, 8'hC1, 1);
        push_byte(1, 8'hD0, 1);
        for (int i = 0; i < 8; i++) step(100, 100);
        exp_q = '{8'hC0, 8'hC1, 8'hD0};
        chk_seq("tie2");

        push_byte(0, 8'h41, 0); push_byte(0, 8'h42, 0); push_byte(0, 8'h43, 1);
        for (int i = 0; i < 7; i++) step(100, 100);
        exp_q = '{8'h41, 8'h42, 8'h43};
        chk_seq("single");

        // Output stall mid-packet with valid held: nothing lost, no timeout.
        pulses = 0;
        for (int i = 0; i < 4; i++) push_byte(0, 8'h50 + 8'(i), i == 3);
        for (int i = 0; i < 3; i++) step(100, 100);
        for (int i = 0; i < 5; i++) step(100, 0);
        for (int i = 0; i < 6; i++) step(100, 100);
        exp_q = '{8'h50, 8'h51, 8'h52, 8'h53};
        chk_seq("bp");
        chk("bp_pulses", 32'(pulses), 0);

        // s1 stalls after one byte; its grant is revoked and pending s0 goes next.
        push_byte(1, 8'h10, 0);
        for (int i = 0; i < 2; i++) step(100, 100);
        push_byte(0, 8'h20, 1);
        pulses = 0;
        for (int i = 0; i < 9; i++) step(100, 100);
        exp_q = '{8'h10, 8'h20};
        chk_seq("timeout");
        chk("timeout_pulses", 32'(pulses), 1);

        // Asynchronous reset while a byte is held in the output register.
        push_byte(0, 8'h60, 0); push_byte(0, 8'h61, 1);
        for (int i = 0; i < 3; i++) step(100, 0);
        chk("pre_rst_mvalid", 32'(m_tvalid), 1);
        @(negedge clk); #2; rst = 1'b1; #1;
        chk_reset_outs("midrst");
        q0.delete(); q1.delete(); drained.delete();
        model_reset();
        s0_tvalid = 0; s1_tvalid = 0;
        @(posedge clk); #1; rst = 1'b0;
        push_byte(0, 8'hE0, 1); push_byte(1, 8'hF0, 1);
        for (int i = 0; i < 7; i++) step(100, 100);
        exp_q = '{8'hE0, 8'hF0};
        chk_seq("post_rst_tie");

        for (int blk = 0; blk < 20; blk++) begin
            int pv, pr;
            pv = (blk % 3 == 0) ? 30 : (blk % 3 == 1) ? 75 : 100;
            pr = (blk % 4 == 0) ? 40 : (blk % 4 == 1) ? 80 : 100;
            for (int i = 0; i < 100; i++) begin
                if (q0.size() < 3 && $urandom_range(5) == 0) push_pkt(0, 1 + int'($urandom_range(3)));
                if (q1.size() < 3 && $urandom_range(5) == 0) push_pkt(1, 1 + int'($urandom_range(3)));
                step(pv, pr);
            end
        end
        for (int i = 0; i < 10; i++) step(0, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Two-requester, packet-locked arbiter that shares the single UART transmitter byte stream (8-bit valid/ready input of the `uart` core) between two byte sources, for example the CPU-side I/O register path and a hardware monitor/debug message source. It grants one source for a whole packet, delimited by `tlast`, so messages from different sources never interleave on `txd`. It registers the selected beat into a one-deep output stage and drops a grant whose owner stalls mid-packet beyond a timeout. The block sits between the requesters and `uart.input_axis_*`.

## Interface
Parameters:
- `TIMEOUT`, default 255: idle cycles allowed mid-packet before the grant is revoked; 0 disables the timeout.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `s0_tdata`  in  8  requester 0 byte
- `s0_tvalid`  in  1  requester 0 byte valid
- `s0_tlast`  in  1  requester 0 last byte of packet
- `s0_tready`  out  1  requester 0 byte accepted when high together with `s0_tvalid`
- `s1_tdata`, `s1_tvalid`, `s1_tlast`, `s1_tready`: same as requester 0, for requester 1
- `m_tdata`  out  8  byte to the UART transmitter
- `m_tvalid`  out  1  output byte valid
- `m_tready`  in  1  UART transmitter ready
- `grant`  out  2  one-hot current owner; 00 when idle
- `timeout_pulse`  out  1  one-cycle pulse when a grant is revoked by timeout

## Operation
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - If exactly one `sN_tvalid` is high, go to OWNN.
  - If both are high, the requester not equal to `last_owner` wins.
  - `last_owner` resets to 1, so s0 wins the first tie.
  - No `tready` is asserted in IDLE.
- OWNN:
  - `sN_tready = !m_tvalid || m_tready`.
  - The other requester's `tready` is 0.
- Beat acceptance (`sN_tvalid && sN_tready`) loads `m_tdata <= sN_tdata` and sets `m_tvalid <= 1`.
- `m_tvalid` clears when `m_tready` is high and no new beat is loaded in the same cycle. Load and drain in the same cycle keeps `m_tvalid = 1` (full throughput).
- An accepted beat with `tlast = 1` sends the FSM to IDLE, with `last_owner <= N`.
- Timeout:
  - Counter of width `$clog2(TIMEOUT+1)`.
  - Cleared on entry to OWNN and on every accepted beat.
  - Increments each OWNN cycle with `sN_tvalid = 0`.
  - Saturates at `TIMEOUT`.
  - When it reaches `TIMEOUT` (`TIMEOUT != 0`): go to IDLE, set `last_owner <= N`, pulse `timeout_pulse` for 1 cycle.
  - A byte already held in the output register still drains normally.
- A stall caused by `m_tready = 0` while `sN_tvalid = 1` does not count toward the timeout.
- `grant` = {state==OWN1, state==OWN0}.
- Reset values: state IDLE, `last_owner` 1, counter 0, `m_tvalid` 0, `m_tdata` 0, `grant` 00, `timeout_pulse` 0, both `tready` 0.
- Reset mid-packet discards the held output byte; no partial packet is resumed.

## Timing
- Arbitration: request seen in IDLE at cycle N gives `grant` and `tready` at N+1.
- First-beat latency: the first byte is accepted on the N+1 edge, and `m_tvalid` is high at N+2.
- Steady state: 1 byte/cycle when `m_tready` is held high. `sN_tready` depends combinationally on `m_tready` (no registered ready).
- Packet switch: a `tlast` beat accepted at cycle M puts the FSM in IDLE at M+1, with the next grant at M+2. There is one dead arbitration cycle between packets.
- Single-byte packet (`tlast` on the first beat) is legal: one OWN cycle, then IDLE.
- Timeout: with `TIMEOUT = T`, T consecutive empty owner cycles, then IDLE plus `timeout_pulse` on the next cycle.
- `m_tdata` and `m_tvalid` are registered outputs.

## Structure
- Shared package `uart_arb_pkg`:
  - state enum (IDLE, OWN0, OWN1);
  - `ARB_NREQ = 2`;
  - default `TIMEOUT` constant.
- One natural sub-module: `axis_out_reg`, the 8-bit one-deep valid/ready output register with load/drain logic.
- FSM, round-robin pointer and timeout counter stay in the top module.

## Test plan
- Single requester: s0 sends 0x41, 0x42, 0x43 (`tlast` on 0x43) with `m_tready = 1`. Required: `m_tdata` shows 41, 42, 43 on consecutive cycles starting 2 cycles after `s0_tvalid`; `grant` 01 then 00.
- Tie: s0 and s1 both valid from IDLE, each with a 2-byte packet (s0: AA, AB; s1: BA, BB). Required: order AA AB BA BB with no interleave, then the next tie goes to s0.
- Backpressure: `m_tready = 0` for 5 cycles mid-packet. Required: `m_tdata` is held, `s0_tready = 0`, no byte lost or duplicated, `timeout_pulse` stays 0.
- Timeout: `TIMEOUT = 4`, s1 sends 0x10 without `tlast`, then drops valid. Required: `timeout_pulse` 4 cycles after acceptance, `grant` 00, a pending s0 request granted next.
- Reset: assert `rst` mid-packet with `m_tvalid = 1`. Required: immediately `m_tvalid = 0`, `grant = 00`, both `tready = 0`; after release, a tie goes to s0.
